// File: rtl/byte_divider_pkg.sv
`default_nettype none
// ============================================================================
// byte_divider_pkg : shared constants and FSM encoding for the byte divider
// Rev 1.0
// ============================================================================
package byte_divider_pkg;

  localparam int W     = 8;
  localparam int STEPS = 8;

  localparam logic [W-1:0] DIV0_Q = 8'hFF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_divider_adder.sv
`default_nettype none
// ============================================================================
// byteAdder : 8-bit ripple-carry adder with carry-in and carry-out
// Rev 1.0
// ============================================================================
module byteAdder
  import byte_divider_pkg::*;
(
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         c,
  output logic [W-1:0] O,
  output logic         o
);

  logic [W:0] w_carry;

  assign w_carry[0] = c;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign O[i]         = A[i] ^ B[i] ^ w_carry[i];
    assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
  end

  assign o = w_carry[W];

endmodule
`default_nettype wire

// File: rtl/byte_divider.sv
`default_nettype none
// ============================================================================
// byte_divider : sequential 8-bit unsigned restoring divider, one bit per clock
// Rev 1.0
// ============================================================================
module byte_divider
  import byte_divider_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam logic [2:0] C_LAST_STEP = 3'(STEPS - 1);

  state_t       r_state;
  logic [W-1:0] r_dq;
  logic [W-1:0] r_dv;
  logic [W-1:0] r_rem;
  logic [2:0]   r_cnt;

  logic [W:0]   w_s;
  logic [W-1:0] w_d;
  logic         w_c8;
  logic         w_ge;
  logic [W-1:0] w_rem_nxt;
  logic [W-1:0] w_dq_nxt;

  // Trial subtract s[7:0] - dv as s[7:0] + ~dv + 1; s[8] covers the 9th bit.
  assign w_s = {r_rem, r_dq[W-1]};

  byteAdder u_sub (
    .A (w_s[W-1:0]),
    .B (~r_dv),
    .c (1'b1),
    .O (w_d),
    .o (w_c8)
  );

  assign w_ge      = w_s[W] | w_c8;
  assign w_rem_nxt = w_ge ? w_d : w_s[W-1:0];
  assign w_dq_nxt  = {r_dq[W-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_dq     <= '0;
      r_dv     <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      Q        <= '0;
      R        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
          if (start) begin
            div_zero <= 1'b0;
            if (B == '0) begin
              r_state  <= ST_DONE;
              Q        <= DIV0_Q;
              R        <= A;
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_dq    <= A;
              r_dv    <= B;
              r_rem   <= '0;
              r_cnt   <= '0;
              busy    <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          r_dq  <= w_dq_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + 3'd1;
          // Q/R only move on the final step so they hold during the run.
          if (r_cnt == C_LAST_STEP) begin
            r_state <= ST_DONE;
            Q       <= w_dq_nxt;
            R       <= w_rem_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_divider.sv
`default_nettype none
// ============================================================================
// tb_byte_divider : vector table, corner sequences and random ops vs. a model
// Rev 1.0
// ============================================================================
module tb_byte_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       div_zero;

  int checks   = 0;
  int failures = 0;

  byte_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
    int         bcnt;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic, divide-by-zero gives all-ones quotient.
  task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic dz);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else begin
      q = 8'(int'(a) / int'(b)); r = 8'(int'(a) % int'(b)); dz = 1'b0;
    end
  endtask

  // Called #1 after the accepting edge; counts edges until done.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) chk("done_timeout", 32'(lat), 32'd8);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dz,
                       output int lat, output int bcnt);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    wait_done(lat, bcnt);
    q = Q; r = R; dz = div_zero;
  endtask

  logic [7:0] q, r, eq, er, ra, rb;
  logic       dz, edz;
  int         lat, bcnt, dcount;

  initial begin
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;

    tbl[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8, 8};
    tbl[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8, 8};
    tbl[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8, 8};
    tbl[3]  = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 8, 8};
    tbl[4]  = '{8'd100, 8'd0,   8'hFF,  8'd100, 1'b1, 0, 0};
    tbl[5]  = '{8'd100, 8'd10,  8'd10,  8'd0,   1'b0, 8, 8};
    tbl[6]  = '{8'd7,   8'd7,   8'd1,   8'd0,   1'b0, 8, 8};
    tbl[7]  = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 0, 0};
    tbl[8]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8, 8};
    tbl[9]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 8, 8};
    tbl[10] = '{8'd255, 8'd2,   8'd127, 8'd1,   1'b0, 8, 8};
    tbl[11] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0, 8, 8};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_Q", 32'(Q), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors, back-to-back (each start lands in the previous DONE cycle).
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].a, tbl[i].b, q, r, dz, lat, bcnt);
      chk($sformatf("tbl%0d_Q", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("tbl%0d_R", i), 32'(r), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_dz", i), 32'(dz), 32'(tbl[i].dz));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_busy", i), 32'(bcnt), 32'(tbl[i].bcnt));
    end

    // done is a single-cycle pulse; outputs hold in IDLE.
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_hold_Q", 32'(Q), 32'd42);

    // start held through RUN with operands churning; result uses captured ones.
    @(negedge clk);
    A = 8'd50; B = 8'd6; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      A = 8'($urandom); B = 8'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk("held_Q", 32'(Q), 32'd8);
    chk("held_R", 32'(R), 32'd2);
    chk("held_lat", 32'(lat), 32'd8);
    @(negedge clk);
    A = 8'd90; B = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat, bcnt);
    chk("b2b_Q", 32'(Q), 32'd10);
    chk("b2b_R", 32'(R), 32'd0);
    chk("b2b_lat", 32'(lat), 32'd8);

    // Divide-by-zero, then an op in flight with Q/R held, then async reset.
    do_op(8'd100, 8'd0, q, r, dz, lat, bcnt);
    chk("dz_Q", 32'(q), 32'hFF);
    chk("dz_flag", 32'(dz), 32'd1);
    @(negedge clk);
    A = 8'd200; B = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("run_hold_Q", 32'(Q), 32'hFF);
    chk("run_hold_R", 32'(R), 32'd100);
    chk("run_dz_clr", 32'(div_zero), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_Q", 32'(Q), 32'd0);
    chk("arst_R", 32'(R), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_dz", 32'(div_zero), 32'd0);
    dcount = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    chk("arst_no_done", 32'(dcount), 32'd0);
    chk("arst_idle_busy", 32'(busy), 32'd0);
    do_op(8'd13, 8'd4, q, r, dz, lat, bcnt);
    chk("post_rst_Q", 32'(q), 32'd3);
    chk("post_rst_R", 32'(r), 32'd1);
    chk("post_rst_lat", 32'(lat), 32'd8);

    // Random back-to-back ops against the reference model plus the invariant.
    for (int n = 0; n < 3000; n++) begin
      ra = 8'($urandom);
      case ($urandom % 8)
        0:       rb = 8'd0;
        1, 2:    rb = 8'($urandom_range(1, 15));
        3:       rb = ra;
        default: rb = 8'($urandom);
      endcase
      ref_div(ra, rb, eq, er, edz);
      do_op(ra, rb, q, r, dz, lat, bcnt);
      chk("rnd_Q", 32'(q), 32'(eq));
      chk("rnd_R", 32'(r), 32'(er));
      chk("rnd_dz", 32'(dz), 32'(edz));
      chk("rnd_lat", 32'(lat), (rb == 8'd0) ? 32'd0 : 32'd8);
      if (rb != 8'd0)
        chk("rnd_invariant", 32'((int'(q) * int'(rb) + int'(r) == int'(ra)) && (r < rb)), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
